// File: rtl/fizzbuzz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fizzbuzz_pkg
//  Purpose  : Shared types and helpers for the FIZZ/BUZZ generator/checker pair
//  Revision : 1.0  initial release
// ============================================================================
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Counter width shared with the generator so exp_count lines up bit-for-bit.
    function automatic int cnt_w(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fizzbuzz_ref.sv
`default_nettype none
// ============================================================================
//  Module   : fizzbuzz_ref
//  Purpose  : Local regeneration of the generator count and FIZZ/BUZZ flags
//  Revision : 1.0  initial release
// ============================================================================
module fizzbuzz_ref #(
    parameter int FIZZ       = 3,
    parameter int BUZZ       = 5,
    parameter int MAX_CYCLES = 100,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             load0,
    input  logic             load1,
    output logic [CNT_W-1:0] count,
    output logic             ref_fizz,
    output logic             ref_buzz,
    output logic             ref_fb
);

    localparam int c_FW  = $clog2(FIZZ) + 1;
    localparam int c_BW  = $clog2(BUZZ) + 1;
    localparam int c_ONE = (MAX_CYCLES == 1) ? 0 : 1;

    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(c_ONE);
    localparam logic [c_FW-1:0]  c_F_ONE   = c_FW'(c_ONE % FIZZ);
    localparam logic [c_BW-1:0]  c_B_ONE   = c_BW'(c_ONE % BUZZ);
    localparam logic [c_FW-1:0]  c_F_LAST  = c_FW'(FIZZ - 1);
    localparam logic [c_BW-1:0]  c_B_LAST  = c_BW'(BUZZ - 1);

    logic [CNT_W-1:0] r_count;
    logic [c_FW-1:0]  r_fph;
    logic [c_BW-1:0]  r_bph;

    // Phase counters track count mod FIZZ/BUZZ and are forced to zero on wrap,
    // since MAX_CYCLES need not be a multiple of either divisor.
    always_ff @(posedge clk) begin
        if (reset || load0) begin
            r_count <= '0;
            r_fph   <= '0;
            r_bph   <= '0;
        end else if (load1) begin
            r_count <= c_CNT_ONE;
            r_fph   <= c_F_ONE;
            r_bph   <= c_B_ONE;
        end else if (advance) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
                r_fph   <= '0;
                r_bph   <= '0;
            end else begin
                r_count <= r_count + 1'b1;
                r_fph   <= (r_fph == c_F_LAST) ? '0 : r_fph + 1'b1;
                r_bph   <= (r_bph == c_B_LAST) ? '0 : r_bph + 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign ref_fizz = (r_fph == '0);
    assign ref_buzz = (r_bph == '0);
    assign ref_fb   = ref_fizz & ref_buzz;

endmodule
`default_nettype wire

// File: rtl/fizzbuzz_checker.sv
`default_nettype none
// ============================================================================
//  Module   : fizzbuzz_checker
//  Purpose  : Locks onto a FIZZ/BUZZ flag stream and counts sample mismatches
//  Revision : 1.0  initial release
// ============================================================================
module fizzbuzz_checker
    import fizzbuzz_pkg::*;
#(
    parameter int FIZZ        = 3,
    parameter int BUZZ        = 5,
    parameter int MAX_CYCLES  = 100,
    parameter int LOCK_LEN    = MAX_CYCLES,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int CNT_W       = cnt_w(MAX_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 fizz,
    input  logic                 buzz,
    input  logic                 fizzbuzz,
    output logic                 locked,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [CNT_W-1:0]     exp_count
);

    localparam int c_VW = $clog2(LOCK_LEN + 1);
    localparam int c_MW = $clog2(LOSS_THRESH + 1);

    localparam logic [c_VW-1:0] c_VERIFY_LAST = c_VW'(LOCK_LEN - 1);
    localparam logic [c_MW-1:0] c_MISS_LAST   = c_MW'(LOSS_THRESH - 1);

    state_t               r_state;
    logic                 r_locked;
    logic                 r_mismatch;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [c_VW-1:0]      r_verify_cnt;
    logic [c_MW-1:0]      r_miss_run;

    logic       w_ref_fizz, w_ref_buzz, w_ref_fb;
    logic [2:0] w_sample, w_ref;
    logic       w_match, w_ones;
    logic       w_advance, w_load0, w_load1;

    assign w_sample = {fizz, buzz, fizzbuzz};
    assign w_ref    = {w_ref_fizz, w_ref_buzz, w_ref_fb};
    assign w_match  = (w_sample == w_ref);
    assign w_ones   = &w_sample;

    fizzbuzz_ref #(
        .FIZZ       (FIZZ),
        .BUZZ       (BUZZ),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ref (
        .clk      (clk),
        .reset    (reset),
        .advance  (w_advance),
        .load0    (w_load0),
        .load1    (w_load1),
        .count    (exp_count),
        .ref_fizz (w_ref_fizz),
        .ref_buzz (w_ref_buzz),
        .ref_fb   (w_ref_fb)
    );

    // An all-ones sample in VERIFY re-anchors to count 0: the first candidate may
    // have been a non-zero multiple of lcm(FIZZ,BUZZ).
    always_comb begin
        w_advance = 1'b0;
        w_load0   = 1'b0;
        w_load1   = 1'b0;
        if (in_valid) begin
            case (r_state)
                SEARCH: w_load1 = w_ones;
                VERIFY: begin
                    if (w_match)     w_advance = 1'b1;
                    else if (w_ones) w_load1   = 1'b1;
                    else             w_load0   = 1'b1;
                end
                LOCKED: begin
                    if (!w_match && (r_miss_run == c_MISS_LAST)) w_load0   = 1'b1;
                    else                                         w_advance = 1'b1;
                end
                default: w_load0 = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SEARCH;
            r_locked     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_count  <= '0;
            r_verify_cnt <= '0;
            r_miss_run   <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    SEARCH: begin
                        if (w_ones) begin
                            r_verify_cnt <= c_VW'(1);
                            if (LOCK_LEN == 1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (w_match) begin
                            r_verify_cnt <= r_verify_cnt + 1'b1;
                            if (r_verify_cnt == c_VERIFY_LAST) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (w_ones) begin
                            r_verify_cnt <= c_VW'(1);
                        end else begin
                            r_state      <= SEARCH;
                            r_verify_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_miss_run <= '0;
                        end else begin
                            r_mismatch <= 1'b1;
                            if (r_err_count != '1)
                                r_err_count <= r_err_count + 1'b1;
                            if (r_miss_run == c_MISS_LAST) begin
                                r_state    <= SEARCH;
                                r_locked   <= 1'b0;
                                r_miss_run <= '0;
                            end else begin
                                r_miss_run <= r_miss_run + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fizzbuzz_checker
//  Purpose  : Self-checking bench for fizzbuzz_checker (8-bit and 2-bit err_count)
//  Revision : 1.0  initial release
// ============================================================================
module tb_fizzbuzz_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       fizz = 1'b0, buzz = 1'b0, fizzbuzz = 1'b0;
    logic       locked, mismatch, locked2, mismatch2;
    logic [7:0] err_count, exp_count, exp_count2;
    logic [1:0] err_count2;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;
    int g = 0;

    always #5 clk = ~clk;

    fizzbuzz_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
        .locked(locked), .mismatch(mismatch),
        .err_count(err_count), .exp_count(exp_count)
    );

    fizzbuzz_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
        .locked(locked2), .mismatch(mismatch2),
        .err_count(err_count2), .exp_count(exp_count2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Model: mode 0 hunting, 1 confirming, 2 locked. Reference flags come
    // straight from count arithmetic.
    int m_mode = 0, m_c = 0, m_run = 0, m_miss = 0, m_err = 0;
    bit m_pulse = 0;

    always @(posedge clk) begin
        logic [2:0] s, r;
        s = {fizz, buzz, fizzbuzz};
        r = {m_c % 3 == 0, m_c % 5 == 0, m_c % 15 == 0};
        m_pulse = 0;
        if (reset) begin
            m_mode = 0; m_c = 0; m_run = 0; m_miss = 0; m_err = 0;
        end else if (in_valid) begin
            if (m_mode == 0) begin
                if (s == 3'b111) begin m_c = 1; m_run = 1; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (s == r) begin
                    m_run++; m_c = (m_c + 1) % 100;
                    if (m_run == 100) m_mode = 2;
                end else if (s == 3'b111) begin
                    m_c = 1; m_run = 1;
                end else begin
                    m_mode = 0; m_c = 0;
                end
            end else begin
                if (s == r) begin
                    m_miss = 0; m_c = (m_c + 1) % 100;
                end else begin
                    m_pulse = 1; m_err++; m_miss++;
                    if (m_miss == 4) begin m_mode = 0; m_c = 0; m_miss = 0; end
                    else m_c = (m_c + 1) % 100;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("locked", locked, m_mode == 2);
            chk("mismatch", mismatch, m_pulse);
            chk("exp_count", exp_count, m_c);
            chk("err_count", err_count, (m_err > 255) ? 255 : m_err);
            chk("locked2", locked2, m_mode == 2);
            chk("err_count2", err_count2, (m_err > 3) ? 3 : m_err);
        end
    end

    task automatic drive(input bit v, input bit f, input bit b, input bit fb);
        @(negedge clk);
        in_valid = v; fizz = f; buzz = b; fizzbuzz = fb;
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int n);
        repeat (n) begin
            drive(1'b1, g % 3 == 0, g % 5 == 0, g % 15 == 0);
            g = (g + 1) % 100;
        end
    endtask

    task automatic bad(input logic [2:0] flip);
        logic [2:0] t;
        t = {g % 3 == 0, g % 5 == 0, g % 15 == 0} ^ flip;
        drive(1'b1, t[2], t[1], t[0]);
        g = (g + 1) % 100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        run_cmp = 1'b1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        chk("rst_exp", exp_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ideal stream from count 0
        g = 0;
        gen(99);
        chk("t1_prelock", locked, 0);
        chk("t1_exp99", exp_count, 99);
        gen(1);
        chk("t1_lock", locked, 1);
        chk("t1_exp0", exp_count, 0);
        gen(400);
        chk("t1_err", err_count, 0);

        // Single buzz flip at count 25
        gen(25);
        bad(3'b010);
        chk("t3_pulse", mismatch, 1);
        chk("t3_err", err_count, 1);
        chk("t3_locked", locked, 1);
        chk("t3_exp26", exp_count, 26);
        gen(1);
        chk("t3_pulse_end", mismatch, 0);
        chk("t3_exp27", exp_count, 27);

        // Four consecutive corrupt samples 40..43 drop lock
        gen(13);
        repeat (3) bad(3'b100);
        chk("t4_still_locked", locked, 1);
        bad(3'b100);
        chk("t4_unlocked", locked, 0);
        chk("t4_err", err_count, 5);
        chk("t4_err2_sat", err_count2, 3);
        chk("t4_exp0", exp_count, 0);
        gen(56);
        chk("t4_search", locked, 0);
        gen(100);
        chk("t4_relock", locked, 1);

        // Idle cycles freeze the reference
        gen(10);
        repeat (3) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("t5_exp_frozen", exp_count, 10);
            chk("t5_no_pulse", mismatch, 0);
        end
        gen(1);
        chk("t5_exp11", exp_count, 11);
        chk("t5_no_pulse2", mismatch, 0);

        // Non-all-ones mismatch while confirming returns to search
        do_reset();
        g = 0;
        gen(5);
        bad(3'b001);
        chk("v_search_exp", exp_count, 0);

        // Stream starting at count 15: false candidate, re-anchor at 0
        do_reset();
        g = 15;
        gen(85);
        chk("t2_exp85", exp_count, 85);
        chk("t2_nolock", locked, 0);
        gen(1);
        chk("t2_recand", exp_count, 1);
        gen(98);
        chk("t2_prelock", locked, 0);
        gen(1);
        chk("t2_lock", locked, 1);
        chk("t2_err", err_count, 0);

        // Six isolated errors saturate the 2-bit counter
        repeat (6) begin
            bad(3'b010);
            gen(5);
        end
        chk("t6_err8", err_count, 6);
        chk("t6_err2", err_count2, 3);
        chk("t6_locked", locked, 1);

        // Reset mid-LOCKED
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1;
        fizz = g % 3 == 0; buzz = g % 5 == 0; fizzbuzz = g % 15 == 0;
        @(posedge clk);
        #1;
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_err", err_count, 0);
        chk("t6_rst_err2", err_count2, 0);
        chk("t6_rst_exp", exp_count, 0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        run_cmp = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
